reg_file: RTL

- Parametrised multi-port register file built from enable-gated storage words.
- Generalises the single-bit enable register to a DEPTH x WIDTH array.
- Provides two combinational read ports, one synchronous write port and one debug read port.
- Used as the MIPS GPR file in the single-cycle and pipelined CPUs; the debug port feeds the Nexys 4 DDR seven-segment display logic.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/reg_cell.sv | 24 ++
 rtl/reg_file.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and MIPS GPR indices.
package cpu_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_V0   = 2;
  localparam int unsigned REG_A0   = 4;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/reg_cell.sv
// Width-bit storage word with write enable and asynchronous active-low clear.
module reg_cell #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_file.sv
// Register file: two combinational read ports with optional write bypass,
// one synchronous write port and a registered debug read port.
module reg_file
  import cpu_pkg::*;
#(
  parameter int unsigned Width   = DefWidth,
  parameter int unsigned Depth   = DefDepth,
  parameter bit          ZeroReg = 1'b1,
  parameter bit          Bypass  = 1'b1,
  localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr1_i,
  output logic [Width-1:0] rdata1_o,
  input  logic [AddrW-1:0] raddr2_i,
  output logic [Width-1:0] rdata2_o,
  input  logic [AddrW-1:0] dbg_addr_i,
  output logic [Width-1:0] dbg_data_o
);

  localparam logic [AddrW:0] DepthL = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] dbg_data_d, dbg_data_q;
  logic             wr_ok;

  // An address is usable when in range and not the hard-wired zero entry.
  function automatic logic addr_ok(logic [AddrW-1:0] a);
    return ({1'b0, a} < DepthL) && !(ZeroReg && (a == '0));
  endfunction

  assign wr_ok = we_i && addr_ok(waddr_i);

  for (genvar i = 0; i < Depth; i++) begin : g_word
    if (ZeroReg && (i == 0)) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_cell
      reg_cell #(
        .Width (Width)
      ) u_cell (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (wr_ok && (waddr_i == AddrW'(i))),
        .d_i    (wdata_i),
        .q_o    (mem[i])
      );
    end
  end

  function automatic logic [Width-1:0] read_port(logic [AddrW-1:0] a);
    logic [Width-1:0] r;
    r = '0;
    if (addr_ok(a)) begin
      r = mem[a];
      if (Bypass && rst_ni && wr_ok && (a == waddr_i)) begin
        r = wdata_i;
      end
    end
    return r;
  endfunction

  always_comb begin
    rdata1_o = read_port(raddr1_i);
    rdata2_o = read_port(raddr2_i);
  end

  always_comb begin
    dbg_data_d = '0;
    if (addr_ok(dbg_addr_i)) begin
      dbg_data_d = mem[dbg_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= dbg_data_d;
    end
  end

  assign dbg_data_o = dbg_data_q;

endmodule
